// File: rtl/multicycle_controller_pkg.sv
// ============================================================================
// multicycle_controller_pkg : shared states, opcodes and mux/ALU encodings
// Revision: 1.0
// ============================================================================
`default_nettype none

package multicycle_controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REGA  = 2'b10;

    localparam logic [1:0] SRCB_REGB = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUREG = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALUOUT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

`default_nettype wire

// File: rtl/multicycle_controller_alu_decoder.sv
// ============================================================================
// alu_decoder : maps alu_op / funct fields to the ALU control code
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_decoder
    import multicycle_controller_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alu_ctrl
);

    always_comb begin
        alu_ctrl = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_ctrl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // Only R-type (op5=1) may subtract; addi ignores bit 30.
                    3'b000:  alu_ctrl = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_ctrl = ALU_SLT;
                    3'b110:  alu_ctrl = ALU_OR;
                    3'b111:  alu_ctrl = ALU_AND;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
            default: alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_controller.sv
// ============================================================================
// multicycle_controller : RISC-V multicycle main FSM with ALU decode
// Revision: 1.0
// ============================================================================
`default_nettype none

module multicycle_controller
    import multicycle_controller_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       mem_write,
    output logic       mem_req,
    output logic       adr_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [1:0] imm_src,
    output logic [2:0] alu_ctrl,
    output logic       illegal_op
);

    state_t     state;
    state_t     next_state;
    logic [1:0] alu_op;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        mem_req    = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_REGB;
        result_src = RES_ALUREG;
        imm_src    = IMM_I;
        alu_op     = ALUOP_ADD;
        illegal_op = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALUOUT;
                ir_write   = mem_ready;
                pc_write   = mem_ready;
                if (mem_ready) next_state = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                imm_src   = IMM_B;
                case (op)
                    OP_LOAD, OP_STORE: next_state = S_MEMADR;
                    OP_RTYPE:          next_state = S_EXECR;
                    OP_ITYPE:          next_state = S_EXECI;
                    OP_BRANCH:         next_state = S_BRANCH;
                    OP_JAL:            next_state = S_JAL;
                    default: begin
                        next_state = S_FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = SRCA_REGA;
                alu_src_b = SRCB_IMM;
                if (op == OP_STORE) begin
                    imm_src    = IMM_S;
                    next_state = S_MEMWRITE;
                end else begin
                    next_state = S_MEMREAD;
                end
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) next_state = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = RES_MEM;
                reg_write  = 1'b1;
                next_state = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
                if (mem_ready) next_state = S_FETCH;
            end
            S_EXECR: begin
                alu_src_a  = SRCA_REGA;
                alu_op     = ALUOP_FUNCT;
                next_state = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a  = SRCA_REGA;
                alu_src_b  = SRCB_IMM;
                alu_op     = ALUOP_FUNCT;
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                next_state = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = SRCA_REGA;
                alu_op     = ALUOP_SUB;
                pc_write   = zero;
                next_state = S_FETCH;
            end
            S_JAL: begin
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                pc_write   = 1'b1;
                next_state = S_ALUWB;
            end
            default: next_state = S_FETCH;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op   (alu_op),
        .funct3   (funct3),
        .op5      (op[5]),
        .funct7b5 (funct7b5),
        .alu_ctrl (alu_ctrl)
    );

endmodule

`default_nettype wire

// File: tb/tb_multicycle_controller.sv
// ============================================================================
// tb_multicycle_controller : per-instruction cycle-sequence model, random mix
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, ir_write, reg_write, mem_write, mem_req, adr_src;
    logic [1:0] alu_src_a, alu_src_b, result_src, imm_src;
    logic [2:0] alu_ctrl;
    logic       illegal_op;
    logic [17:0] obs;

    int n_checks = 0;
    int n_pass   = 0;

    multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .ir_write   (ir_write),
        .reg_write  (reg_write),
        .mem_write  (mem_write),
        .mem_req    (mem_req),
        .adr_src    (adr_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .result_src (result_src),
        .imm_src    (imm_src),
        .alu_ctrl   (alu_ctrl),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    assign obs = {pc_write, ir_write, reg_write, mem_write, mem_req, adr_src,
                  alu_src_a, alu_src_b, result_src, imm_src, alu_ctrl, illegal_op};

    task automatic check(input string tag, input logic [17:0] got, input logic [17:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %05h expected %05h at %0t", tag, got, exp, $time);
    endtask

    // Expected output bundle, same field order as obs.
    function automatic logic [17:0] pk(input logic pcw, input logic irw, input logic rw,
                                       input logic mw, input logic mr, input logic adr,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] rs, input logic [1:0] imm,
                                       input logic [2:0] alu, input logic ill);
        return {pcw, irw, rw, mw, mr, adr, a, b, rs, imm, alu, ill};
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic bit is_legal(input logic [6:0] o);
        return o == 7'b0000011 || o == 7'b0100011 || o == 7'b0110011 ||
               o == 7'b0010011 || o == 7'b1100011 || o == 7'b1101111;
    endfunction

    function automatic logic [2:0] ref_alu(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        case (f3)
            3'b000:  return (o == 7'b0110011 && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    // One clock cycle: drive inputs, check at the falling edge, advance past the rising edge.
    task automatic cyc(input string tag, input logic rdy, input logic z, input logic [17:0] exp);
        mem_ready = rdy;
        zero      = z;
        @(negedge clk);
        check(tag, obs, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input logic z, input int fw, input int mw);
        logic [17:0] aluwb;
        aluwb = pk(0,0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0);
        op = o; funct3 = f3; funct7b5 = f7;
        for (int i = 0; i < fw; i++)
            cyc("fetch_wait", 1'b0, rbit(), pk(0,0,0,0,1,0,2'b00,2'b10,2'b10,2'b00,3'b000,0));
        cyc("fetch", 1'b1, rbit(), pk(1,1,0,0,1,0,2'b00,2'b10,2'b10,2'b00,3'b000,0));
        cyc("decode", rbit(), rbit(),
            pk(0,0,0,0,0,0,2'b01,2'b01,2'b00,2'b10,3'b000,!is_legal(o)));
        case (o)
            7'b0000011: begin
                cyc("memadr_ld", rbit(), rbit(), pk(0,0,0,0,0,0,2'b10,2'b01,2'b00,2'b00,3'b000,0));
                for (int i = 0; i < mw; i++)
                    cyc("memread_wait", 1'b0, rbit(), pk(0,0,0,0,1,1,2'b00,2'b00,2'b00,2'b00,3'b000,0));
                cyc("memread", 1'b1, rbit(), pk(0,0,0,0,1,1,2'b00,2'b00,2'b00,2'b00,3'b000,0));
                cyc("memwb", rbit(), rbit(), pk(0,0,1,0,0,0,2'b00,2'b00,2'b01,2'b00,3'b000,0));
            end
            7'b0100011: begin
                cyc("memadr_st", rbit(), rbit(), pk(0,0,0,0,0,0,2'b10,2'b01,2'b00,2'b01,3'b000,0));
                for (int i = 0; i < mw; i++)
                    cyc("memwrite_wait", 1'b0, rbit(), pk(0,0,0,1,1,1,2'b00,2'b00,2'b00,2'b00,3'b000,0));
                cyc("memwrite", 1'b1, rbit(), pk(0,0,0,1,1,1,2'b00,2'b00,2'b00,2'b00,3'b000,0));
            end
            7'b0110011: begin
                cyc("execr", rbit(), rbit(), pk(0,0,0,0,0,0,2'b10,2'b00,2'b00,2'b00,ref_alu(o,f3,f7),0));
                cyc("aluwb", rbit(), rbit(), aluwb);
            end
            7'b0010011: begin
                cyc("execi", rbit(), rbit(), pk(0,0,0,0,0,0,2'b10,2'b01,2'b00,2'b00,ref_alu(o,f3,f7),0));
                cyc("aluwb", rbit(), rbit(), aluwb);
            end
            7'b1100011:
                cyc("branch", rbit(), z, pk(z,0,0,0,0,0,2'b10,2'b00,2'b00,2'b00,3'b001,0));
            7'b1101111: begin
                cyc("jal", rbit(), rbit(), pk(1,0,0,0,0,0,2'b01,2'b10,2'b00,2'b00,3'b000,0));
                cyc("aluwb", rbit(), rbit(), aluwb);
            end
            default: ;
        endcase
    endtask

    logic [17:0] fetch_idle;
    logic [17:0] fetch_go;

    initial begin
        fetch_idle = pk(0,0,0,0,1,0,2'b00,2'b10,2'b10,2'b00,3'b000,0);
        fetch_go   = pk(1,1,0,0,1,0,2'b00,2'b10,2'b10,2'b00,3'b000,0);
        reset = 1'b1; op = 7'b0; funct3 = 3'b0; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b0;
        #1;
        check("reset_async", obs, fetch_idle);
        @(posedge clk); #1;
        @(negedge clk);
        check("reset_hold", obs, fetch_idle);
        mem_ready = 1'b1;
        #1;
        check("reset_hold_ready", obs, fetch_go);
        mem_ready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;

        run_instr(7'b0110011, 3'b000, 1'b0, 1'b0, 0, 0);  // add
        run_instr(7'b0110011, 3'b000, 1'b1, 1'b0, 0, 0);  // sub
        run_instr(7'b0010011, 3'b000, 1'b1, 1'b0, 0, 0);  // addi, bit30 set
        run_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 1, 3);  // lw, 3 wait cycles
        run_instr(7'b1100011, 3'b000, 1'b0, 1'b1, 0, 0);  // beq taken
        run_instr(7'b1100011, 3'b000, 1'b0, 1'b0, 0, 0);  // beq not taken
        run_instr(7'b1111111, 3'b000, 1'b0, 1'b0, 0, 0);  // illegal
        run_instr(7'b1101111, 3'b000, 1'b0, 1'b0, 0, 0);  // jal
        run_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 2, 2);  // sw, waits
        run_instr(7'b0110011, 3'b111, 1'b0, 1'b0, 0, 0);  // and
        run_instr(7'b0010011, 3'b110, 1'b0, 1'b0, 0, 0);  // ori
        run_instr(7'b0110011, 3'b010, 1'b1, 1'b0, 0, 0);  // slt

        // Reset mid MEMWRITE wait: mem_write must fall without a clock edge.
        op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0;
        cyc("rst_fetch", 1'b1, 1'b0, fetch_go);
        cyc("rst_decode", 1'b0, 1'b0, pk(0,0,0,0,0,0,2'b01,2'b01,2'b00,2'b10,3'b000,0));
        cyc("rst_memadr", 1'b0, 1'b0, pk(0,0,0,0,0,0,2'b10,2'b01,2'b00,2'b01,3'b000,0));
        mem_ready = 1'b0;
        @(negedge clk);
        check("rst_memwrite_wait", obs, pk(0,0,0,1,1,1,2'b00,2'b00,2'b00,2'b00,3'b000,0));
        #1;
        reset = 1'b1;
        #1;
        check("rst_mem_write_low", {17'b0, mem_write}, 18'b0);
        check("rst_forced_fetch", obs, fetch_idle);
        @(posedge clk); #1;
        reset = 1'b0;
        run_instr(7'b0110011, 3'b000, 1'b1, 1'b0, 0, 0);

        for (int n = 0; n < 150; n++) begin
            logic [6:0] o;
            case ($urandom_range(0, 6))
                0: o = 7'b0000011;
                1: o = 7'b0100011;
                2: o = 7'b0110011;
                3: o = 7'b0010011;
                4: o = 7'b1100011;
                5: o = 7'b1101111;
                default: begin
                    o = 7'($urandom);
                    while (is_legal(o)) o = 7'($urandom);
                end
            endcase
            run_instr(o, 3'($urandom), rbit(), rbit(),
                      int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have one clock, and its reset SHALL be asynchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous active-high reset.
REQ-004 op  input  7  opcode field of the instruction register.
REQ-005 funct3  input  3  funct3 field of the instruction register.
REQ-006 funct7b5  input  1  instruction bit 30.
REQ-007 zero  input  1  ALU zero flag, valid in the cycle it is sampled.
REQ-008 mem_ready  input  1  shared instruction/data memory has completed the current access.
REQ-009 pc_write, ir_write, reg_write, mem_write, mem_req  output  1 each  registered-state-decoded strobes.
REQ-010 adr_src  output  1  memory address select: 0 = PC, 1 = ALU result register.
REQ-011 alu_src_a  output  2  00 = PC, 01 = old PC, 10 = register A.
REQ-012 alu_src_b  output  2  00 = register B, 01 = immediate, 10 = constant 4.
REQ-013 result_src  output  2  00 = ALU result register, 01 = memory data, 10 = ALU output.
REQ-014 imm_src  output  2  00 = I, 01 = S, 10 = B, 11 = J.
REQ-015 alu_ctrl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-016 illegal_op  output  1  one-cycle pulse for an unsupported opcode.

Function
REQ-017 States SHALL be FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL.
REQ-018 FETCH: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, add, result_src=10; ir_write=pc_write=1 only when mem_ready=1; stay in FETCH while mem_ready=0; go to DECODE on mem_ready=1.
REQ-019 DECODE: alu_src_a=01, alu_src_b=01, imm_src=10, add (branch target precompute).
REQ-019 (cont.) DECODE next state: op 0000011/0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BRANCH; 1101111 -> JAL; otherwise FETCH with illegal_op=1 for that cycle.
REQ-020 MEMADR: alu_src_a=10, alu_src_b=01, add; imm_src=00 for load, 01 for store; next state MEMREAD for load, MEMWRITE for store.
REQ-021 MEMREAD: mem_req=1, adr_src=1; hold until mem_ready, then MEMWB.
REQ-022 MEMWB: result_src=01, reg_write=1, then FETCH.
REQ-023 MEMWRITE: mem_req=1, mem_write=1, adr_src=1; hold until mem_ready, then FETCH; mem_write SHALL drop the cycle after the accepting edge.
REQ-024 EXECR: alu_src_a=10, alu_src_b=00. EXECI: alu_src_a=10, alu_src_b=01, imm_src=00. Both SHALL go to ALUWB.
REQ-025 ALUWB: result_src=00, reg_write=1, then FETCH.
REQ-026 BRANCH: alu_src_a=10, alu_src_b=00, sub, result_src=00; pc_write=zero; then FETCH.
REQ-027 JAL: alu_src_a=01, alu_src_b=10, add, result_src=00, pc_write=1, then ALUWB.
REQ-028 ALU decode (R/I types, add=0 by default): funct3 000 -> sub if op[5]&funct7b5, else add; 010 -> slt; 110 -> or; 111 -> and; any other funct3 -> add.
REQ-029 Every output not named in a state SHALL be 0 in that state.
REQ-030 Latency SHALL be: load 5 cycles, store 4, R/I 4, branch 3, jal 4, each excluding mem_ready wait cycles.

Reset
REQ-031 Reset SHALL force state to FETCH immediately, including mid-wait in MEMREAD or MEMWRITE; no strobe other than FETCH's decoded values SHALL appear while reset is held.
REQ-032 The first FETCH after reset release SHALL behave identically to any other FETCH.

Structure
REQ-033 A shared package SHALL hold the state enumeration, the opcode constants and the alu_ctrl/src encodings.
REQ-034 ALU decode SHALL be a combinational sub-module, alu_decoder, with inputs alu_op[1:0], funct3, op5 and funct7b5.

Verification
REQ-035 add x3,x1,x2 (op 0110011, f3 000, f7b5 0), mem_ready=1 -> FETCH,DECODE,EXECR,ALUWB; alu_ctrl 000 in EXECR; reg_write=1 only in ALUWB.
REQ-036 sub (f7b5 1) -> alu_ctrl 001 in EXECR; addi with bit30=1 -> alu_ctrl 000.
REQ-037 lw with mem_ready low for 3 cycles in MEMREAD -> mem_req/adr_src held for 4 cycles, then MEMWB with reg_write=1, result_src=01.
REQ-038 beq, zero=1 -> pc_write=1 in BRANCH; zero=0 -> pc_write=0; 3 cycles in both cases.
REQ-039 op 1111111 -> illegal_op pulses exactly 1 cycle in DECODE; next state FETCH; no write strobes.
REQ-040 Reset asserted asynchronously during a MEMWRITE wait -> mem_write=0 before the next clock edge; state FETCH after release.
